exe_unit_w1: RTL and testbench
==============================

# exe_unit_w1

Registered 4-operation signed execution unit: add, subtract, signed less-than compare, and sign-magnitude to two's-complement conversion. Each rising clock edge samples the operands and opcode. The result and a 4-bit status word are presented one cycle later. It sits in the datapath as a single-issue ALU stage. exe_unit_w1_rtl is its fixed-width (m=4, n=2) synthesis twin, with identical ports and cycle-identical behaviour.

## Interface
- m, default 4: operand/result width in bits (≥2).
- n, default 2: opcode width in bits (≥2).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rsn  in  1  reset, synchronous, active-low.
- i_oper  in  n  opcode.
- i_argA  in  m  operand A, signed two's complement (sign-magnitude for op 11).
- i_argB  in  m  operand B, signed two's complement.
- o_result  out  m  registered result.
- o_status  out  4  registered flags:
  - [0] ZERO
  - [1] NEG
  - [2] OVF
  - [3] ERR
- The unit has one clock. Reset is synchronous and active-low: i_rsn=0 at a rising i_clk edge clears the state.

## Operation
- Opcodes (low 2 bits; any nonzero bit above bit 1 when n>2 is invalid):
  - 00 ADD: result = A+B mod 2^m. OVF=1 when A and B have the same sign and the result sign differs.
  - 01 SUB: result = A−B mod 2^m. OVF=1 when A and B have different signs and the result sign differs from A.
  - 10 LT: result = 1 if A<B signed, else 0. OVF=0.
  - 11 SM2TC: A is read as sign-magnitude, and B is ignored.
    - A[m−1]=0: result = A.
    - A[m−1]=1: result = −A[m−2:0] in two's complement.
    - A = 1000…0 (negative zero): result = 0 and ERR=1.
    - OVF=0.
- Invalid opcode: result = 0, ERR=1, other flags computed from that result (ZERO=1).
- ZERO = (result == 0). NEG = result[m−1]. ERR is set only by an invalid opcode or negative-zero input.
- Flags are computed from the same-cycle combinational result and registered together with it.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on o_result/o_status after edge k and hold until edge k+1.
- No handshake. One operation is accepted every cycle, and inputs may change at any time between edges.
- Reset: i_rsn=0 at an edge sets o_result=0 and o_status=0000. Reset has priority over any operation.
- Reset mid-stream: the operation sampled at the reset edge is discarded. The first valid result follows the first edge with i_rsn=1.
- Before the first reset the outputs are undefined.
- Only the values present at the sampling edge matter; changes between edges have no effect.

## Structure
- Package exe_unit_w1_pkg holds:
  - opcode enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_LT=2'b10, OP_SM2TC=2'b11);
  - status bit index constants (ST_ZERO=0, ST_NEG=1, ST_OVF=2, ST_ERR=3).
- Sub-module exe_unit_w1_core is purely combinational and parameterised by m and n. It produces the next result and status.
- The top module holds only the output registers with synchronous reset.
- exe_unit_w1_rtl instantiates the same core with m=4, n=2.

## Test plan
- Reset: hold i_rsn=0 for one edge with any inputs -> o_result=0000, o_status=0000. Release, then apply ADD 1111+0000 -> next edge gives 1111, status 0010.
- ADD boundaries:
  - 1111+0111 -> 0110, status 0000.
  - 0111+1111 -> 0110, status 0000.
  - 0111+0111 -> 1110, status 0110 (NEG, OVF).
- SUB boundaries:
  - 0111−1111 -> 1000, status 0110.
  - 1000−0001 -> 0111, status 0100.
  - 0101−0101 -> 0000, status 0001.
- LT:
  - A=1111, B=0111 -> 0001, status 0000.
  - A=0111, B=1111 -> 0000, status 0001.
- SM2TC (B=1111, ignored):
  - A=1011 -> 1101, status 0010.
  - A=1000 -> 0000, status 1001.
  - A=0101 -> 0101, status 0000.
- Equivalence and reset: run random back-to-back stimulus on exe_unit_w1 (m=4, n=2) and exe_unit_w1_rtl -> outputs match every cycle. Assert i_rsn=0 mid-stream -> both clear to 0 on that edge.

Source files
------------

// File: rtl/exe_unit_w1_pkg.sv
// Shared opcode and status-bit definitions for the exe_unit_w1 execution unit.
package exe_unit_w1_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LT    = 2'b10,
        OP_SM2TC = 2'b11
    } op_e;

    localparam int ST_ZERO = 0;
    localparam int ST_NEG  = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_ERR  = 3;

endpackage

// File: rtl/exe_unit_w1_core.sv
// Combinational datapath: computes the next result and status word from the
// opcode and operands. Registered by the enclosing stage.
module exe_unit_w1_core
    import exe_unit_w1_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic [n-1:0] oper,
    input  logic [m-1:0] arg_a,
    input  logic [m-1:0] arg_b,
    output logic [m-1:0] result,
    output logic [3:0]   status
);

    logic [m-1:0] sum;
    logic [m-1:0] diff;
    logic [m-1:0] mag;
    logic         op_valid;
    logic         ovf;
    logic         err;
    op_e          op;

    assign sum  = arg_a + arg_b;
    assign diff = arg_a - arg_b;
    // Magnitude field of a sign-magnitude operand, zero-extended to m bits.
    assign mag  = {1'b0, arg_a[m-2:0]};
    // Any set opcode bit above bit 1 marks the opcode invalid; the shift keeps
    // this legal when n == 2 (no upper bits exist).
    assign op_valid = ((oper >> 2) == '0);
    assign op = op_e'(oper[1:0]);

    // Select the operation result and its overflow/error flags.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        result = '0;
        ovf    = 1'b0;
        err    = 1'b0;
        if (!op_valid) begin
            err = 1'b1;
        end else begin
            case (op)
                OP_ADD: begin
                    result = sum;
                    ovf    = (arg_a[m-1] == arg_b[m-1]) && (sum[m-1] != arg_a[m-1]);
                end
                OP_SUB: begin
                    result = diff;
                    ovf    = (arg_a[m-1] != arg_b[m-1]) && (diff[m-1] != arg_a[m-1]);
                end
                OP_LT: begin
                    result = {{(m-1){1'b0}}, ($signed(arg_a) < $signed(arg_b))};
                end
                OP_SM2TC: begin
                    if (!arg_a[m-1]) begin
                        result = arg_a;
                    end else if (arg_a[m-2:0] == '0) begin
                        // Negative zero has no two's-complement counterpart.
                        err = 1'b1;
                    end else begin
                        result = '0 - mag;
                    end
                end
                default: begin
                    err = 1'b1;
                end
            endcase
        end
    end

    // Flags derive from the final result of this same cycle.
    always_comb begin
        status          = '0;
        status[ST_ZERO] = (result == '0);
        status[ST_NEG]  = result[m-1];
        status[ST_OVF]  = ovf;
        status[ST_ERR]  = err;
    end

endmodule

// File: rtl/exe_unit_w1_rtl.sv
// Fixed-width (m=4, n=2) synthesis twin of exe_unit_w1, built on the same core.
module exe_unit_w1_rtl
    import exe_unit_w1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rsn,
    input  logic [1:0] i_oper,
    input  logic [3:0] i_argA,
    input  logic [3:0] i_argB,
    output logic [3:0] o_result,
    output logic [3:0] o_status
);

    logic [3:0] next_result;
    logic [3:0] next_status;

    exe_unit_w1_core #(.m(4), .n(2)) u_core (
        .oper   (i_oper),
        .arg_a  (i_argA),
        .arg_b  (i_argB),
        .result (next_result),
        .status (next_status)
    );

    // Output register with synchronous active-low clear.
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            o_result <= '0;
            o_status <= '0;
        end else begin
            o_result <= next_result;
            o_status <= next_status;
        end
    end

endmodule

// File: rtl/exe_unit_w1.sv
// Single-issue ALU stage: one operation accepted per cycle, result and status
// registered with one cycle of latency.
module exe_unit_w1
    import exe_unit_w1_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic [n-1:0] i_oper,
    input  logic [m-1:0] i_argA,
    input  logic [m-1:0] i_argB,
    output logic [m-1:0] o_result,
    output logic [3:0]   o_status
);

    logic [m-1:0] next_result;
    logic [3:0]   next_status;

    exe_unit_w1_core #(.m(m), .n(n)) u_core (
        .oper   (i_oper),
        .arg_a  (i_argA),
        .arg_b  (i_argB),
        .result (next_result),
        .status (next_status)
    );

    // Output register; reset wins over the operation sampled on the same edge.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!i_rsn) begin
            o_result <= '0;
            o_status <= '0;
        end else begin
            o_result <= next_result;
            o_status <= next_status;
        end
    end

endmodule

// File: tb/tb_exe_unit_w1.sv
// Self-checking bench for exe_unit_w1 (m=4: n=2 and n=3) and its fixed-width twin.
module tb_exe_unit_w1;

    logic       clk;
    logic       rsn;
    logic [2:0] op3;
    logic [1:0] op2;
    logic [3:0] arg_a;
    logic [3:0] arg_b;
    logic [3:0] res_w,  st_w;
    logic [3:0] res_r,  st_r;
    logic [3:0] res_3,  st_3;

    int tests_run = 0;
    int tests_failed = 0;

    assign op2 = op3[1:0];

    exe_unit_w1 #(.m(4), .n(2)) dut (
        .i_clk(clk), .i_rsn(rsn), .i_oper(op2), .i_argA(arg_a), .i_argB(arg_b),
        .o_result(res_w), .o_status(st_w)
    );

    exe_unit_w1_rtl dut_rtl (
        .i_clk(clk), .i_rsn(rsn), .i_oper(op2), .i_argA(arg_a), .i_argB(arg_b),
        .o_result(res_r), .o_status(st_r)
    );

    exe_unit_w1 #(.m(4), .n(3)) dut_n3 (
        .i_clk(clk), .i_rsn(rsn), .i_oper(op3), .i_argA(arg_a), .i_argB(arg_b),
        .o_result(res_3), .o_status(st_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: value semantics with plain integers; returns {result, status}.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        int sa, sb, r, mag;
        logic [3:0] rv;
        logic ovf, err;
        sa  = a[3] ? int'(a) - 16 : int'(a);
        sb  = b[3] ? int'(b) - 16 : int'(b);
        r   = 0;
        ovf = 1'b0;
        err = 1'b0;
        if (op[2]) begin
            err = 1'b1;
        end else begin
            case (op[1:0])
                2'd0: begin r = sa + sb; ovf = (r > 7) || (r < -8); end
                2'd1: begin r = sa - sb; ovf = (r > 7) || (r < -8); end
                2'd2: r = (sa < sb) ? 1 : 0;
                default: begin
                    mag = int'(a) % 8;
                    if (a[3] && mag == 0) err = 1'b1;
                    r = a[3] ? -mag : mag;
                end
            endcase
        end
        rv = r[3:0];
        return {rv, err, ovf, rv[3], (rv == 4'd0)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got result=%b status=%b, expected result=%b status=%b",
                     name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    // Drive one operation, let one edge sample it, then settle past the edge.
    task automatic step(input logic r, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b);
        rsn   = r;
        op3   = op;
        arg_a = a;
        arg_b = b;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_res;
        logic [3:0] exp_st;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] exp;
        logic [7:0] held;

        vecs[0]  = '{"add_after_reset", 2'b00, 4'b1111, 4'b0000, 4'b1111, 4'b0010};
        vecs[1]  = '{"add_m1_p7",       2'b00, 4'b1111, 4'b0111, 4'b0110, 4'b0000};
        vecs[2]  = '{"add_p7_m1",       2'b00, 4'b0111, 4'b1111, 4'b0110, 4'b0000};
        vecs[3]  = '{"add_ovf",         2'b00, 4'b0111, 4'b0111, 4'b1110, 4'b0110};
        vecs[4]  = '{"sub_ovf_pos",     2'b01, 4'b0111, 4'b1111, 4'b1000, 4'b0110};
        vecs[5]  = '{"sub_ovf_neg",     2'b01, 4'b1000, 4'b0001, 4'b0111, 4'b0100};
        vecs[6]  = '{"sub_zero",        2'b01, 4'b0101, 4'b0101, 4'b0000, 4'b0001};
        vecs[7]  = '{"lt_true",         2'b10, 4'b1111, 4'b0111, 4'b0001, 4'b0000};
        vecs[8]  = '{"lt_false",        2'b10, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
        vecs[9]  = '{"sm2tc_neg",       2'b11, 4'b1011, 4'b1111, 4'b1101, 4'b0010};
        vecs[10] = '{"sm2tc_negzero",   2'b11, 4'b1000, 4'b1111, 4'b0000, 4'b1001};
        vecs[11] = '{"sm2tc_pos",       2'b11, 4'b0101, 4'b1111, 4'b0101, 4'b0000};

        rsn = 1'b0; op3 = 3'b000; arg_a = 4'b0111; arg_b = 4'b0111;
        #3;

        // Reset with a live ADD present: it must be discarded.
        step(1'b0, 3'b000, 4'b0111, 4'b0111);
        check("reset_w",   {res_w, st_w}, 8'h00);
        check("reset_rtl", {res_r, st_r}, 8'h00);
        check("reset_n3",  {res_3, st_3}, 8'h00);

        // Directed table, every vector checked on all three instances.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, {1'b0, vecs[i].op}, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_w"},   {res_w, st_w}, {vecs[i].exp_res, vecs[i].exp_st});
            check({vecs[i].name, "_rtl"}, {res_r, st_r}, {vecs[i].exp_res, vecs[i].exp_st});
            check({vecs[i].name, "_n3"},  {res_3, st_3}, {vecs[i].exp_res, vecs[i].exp_st});
        end

        // Invalid opcode (upper bit set) on the n=3 instance.
        step(1'b1, 3'b100, 4'b0011, 4'b0010);
        check("invalid_op_n3", {res_3, st_3}, {4'b0000, 4'b1001});
        check("invalid_op_low_bits_w", {res_w, st_w}, {4'b0101, 4'b0000});

        // Output holds between edges while inputs change.
        step(1'b1, 3'b000, 4'b0010, 4'b0011);
        held = {res_w, st_w};
        check("hold_sampled", held, 8'h50);
        op3 = 3'b001; arg_a = 4'b1000; arg_b = 4'b0001;
        #3;
        check("hold_mid_cycle", {res_w, st_w}, held);
        #2;
        op3 = 3'b011; arg_a = 4'b1101;
        #2;
        check("hold_late_cycle", {res_w, st_w}, held);

        // Reset mid-stream, then the very next edge with rsn=1 gives a result.
        step(1'b0, 3'b000, 4'b0111, 4'b0111);
        check("midreset_clear", {res_w, st_w}, 8'h00);
        step(1'b1, 3'b001, 4'b0011, 4'b0101);
        check("midreset_first", {res_w, st_w}, model(3'b001, 4'b0011, 4'b0101));

        // Randomised back-to-back stream with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [2:0] op;
            logic [3:0] a, b;
            r  = ($urandom_range(0, 15) != 0);
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            step(r, op, a, b);
            exp = r ? model({1'b0, op[1:0]}, a, b) : 8'h00;
            check("rand_w",   {res_w, st_w}, exp);
            check("rand_rtl", {res_r, st_r}, exp);
            exp = r ? model(op, a, b) : 8'h00;
            check("rand_n3",  {res_3, st_3}, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
